// File: rtl/mult_requester.sv
`default_nettype none
// ============================================================================
// Module   : mult_requester
// Brief    : Initiator for the shift-add multiplier valid_data/done/ack
//            handshake. Takes operand pairs upstream, runs one multiply at a
//            time and hands the product downstream on valid/ready.
//            Optional WAIT timeout: define MULT_REQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_requester #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_valid_data,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 mul_ack,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_product,
    output logic [15:0]          txn_count,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_ACK  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_zero_op;
    logic   w_capture;
    logic   w_timeout;
    logic   w_out_fire;
    logic   w_tmo_hit;

    always_comb begin
        w_state_nxt = S_IDLE;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_out_fire  = 1'b0;
        w_zero_op   = (in_a == '0) || (in_b == '0);
        case (r_state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_zero_op ? S_OUT : S_SEND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A real done always wins over a timeout landing on the same edge.
                if (mul_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ACK;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_ACK:  w_state_nxt = mul_done ? S_ACK : S_OUT;
            S_OUT: begin
                if (res_ready) begin
                    w_out_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= S_IDLE;
            in_ready       <= 1'b0;
            mul_valid_data <= 1'b0;
            mul_ack        <= 1'b0;
            res_valid      <= 1'b0;
            mul_a          <= '0;
            mul_b          <= '0;
            res_product    <= '0;
            txn_count      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            in_ready       <= (w_state_nxt == S_IDLE);
            mul_valid_data <= (w_state_nxt == S_SEND);
            mul_ack        <= (w_state_nxt == S_ACK) || w_timeout;
            res_valid      <= (w_state_nxt == S_OUT);
            if (w_accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
                if (w_zero_op) begin
                    res_product <= '0;
                end
            end
            if (w_capture) begin
                res_product <= mul_product;
            end else if (w_timeout) begin
                res_product <= '0;
            end
            if (w_out_fire) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

`ifdef MULT_REQ_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_wait_cnt;

    // The edge that would bring the count to TIMEOUT is the abort edge.
    assign w_tmo_hit = (r_wait_cnt == c_tmo_last);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wait_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((w_state_nxt == S_WAIT) && (r_state != S_WAIT)) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                timeout_err <= 1'b1;
            end else if (w_accept) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_requester.sv
`default_nettype none
// Bench for mult_requester: a behavioural multiplier on the far side and a
// transaction-level reference model deriving product, latency and strobe counts.
module tb_mult_requester;

    localparam int W   = 32;
    localparam int TMO = 8;

    logic            Clock = 1'b0;
    logic            Reset_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic            mul_valid_data;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_done;
    logic [2*W-1:0]  mul_product = '0;
    logic            mul_ack;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [2*W-1:0]  res_product;
    logic [15:0]     txn_count;
    logic            timeout_err;

    logic            mdl_done = 1'b0;
    logic            spur = 1'b0;
    assign mul_done = mdl_done | spur;

    int checks = 0;
    int errors = 0;
    int vd_cnt = 0;
    int ack_cnt = 0;
    int mdl_lat = 1;
    bit mdl_never = 1'b0;
    int exp_txn = 0;

    mult_requester #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_valid_data(mul_valid_data), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product), .mul_ack(mul_ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .txn_count(txn_count), .timeout_err(timeout_err)
    );

    always #5 Clock = ~Clock;

    // Multiplier stand-in: answers mdl_lat cycles after the start strobe,
    // holds done until ack is seen, then drops it one cycle later.
    initial begin : multiplier_model
        int            phase;
        int            cnt;
        logic [W-1:0]  ma;
        logic [W-1:0]  mb;
        phase = 0;
        cnt   = 0;
        ma    = '0;
        mb    = '0;
        forever begin
            @(negedge Clock);
            if (!Reset_n) begin
                mdl_done = 1'b0;
                phase    = 0;
            end else begin
                if (mul_ack) ack_cnt++;
                if (mul_valid_data) begin
                    vd_cnt++;
                    ma       = mul_a;
                    mb       = mul_b;
                    cnt      = mdl_lat;
                    phase    = 1;
                    mdl_done = 1'b0;
                end else begin
                    case (phase)
                        1: begin
                            mul_product = {$urandom, $urandom};
                            if (!mdl_never) begin
                                if (cnt <= 1) begin
                                    mdl_done    = 1'b1;
                                    mul_product = {32'd0, ma} * {32'd0, mb};
                                    phase       = 2;
                                end else begin
                                    cnt--;
                                end
                            end
                        end
                        2: if (mul_ack) phase = 3;
                        3: begin
                            mdl_done    = 1'b0;
                            mul_product = {$urandom, $urandom};
                            phase       = 0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction. 'cyc' counts sampled negedges after the accept
    // edge until res_valid is seen: bypass shows on the first, a normal
    // multiply enters OUT on edge lat+3 (seen on sample lat+4), a timeout
    // enters OUT on edge TMO+1 (seen on sample TMO+2).
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input int hold, input bit never);
        int          cyc;
        int          vd0;
        int          ack0;
        bit          zero;
        bit          tmo;
        int          exp_lat;
        logic [63:0] exp_p;
        zero    = (a == 0) || (b == 0);
        tmo     = never && !zero;
        exp_p   = (zero || tmo) ? 64'd0 : {32'd0, a} * {32'd0, b};
        exp_lat = zero ? 1 : (tmo ? TMO + 2 : lat + 4);
        mdl_lat   = lat;
        mdl_never = never;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge Clock);
            cyc++;
        end
        check("in_ready_idle", in_ready, 1);
        vd0  = vd_cnt;
        ack0 = ack_cnt;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge Clock);
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        check("mul_a_latch", mul_a, a);
        check("mul_b_latch", mul_b, b);
        check("terr_clear_on_accept", timeout_err, 0);
        check("in_ready_busy", in_ready, 0);
        cyc = 1;
        while (!res_valid && cyc < 200) begin
            @(negedge Clock);
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("res_product", res_product, exp_p);
        check("timeout_err", timeout_err, tmo);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            @(negedge Clock);
            check("hold_res_valid", res_valid, 1);
            check("hold_res_product", res_product, exp_p);
            check("hold_in_ready", in_ready, 0);
            check("hold_mul_a", mul_a, a);
        end
        in_valid = 1'b0;
        check("valid_data_pulses", vd_cnt - vd0, zero ? 0 : 1);
        check("ack_cycles", ack_cnt - ack0, zero ? 0 : (tmo ? 1 : 2));
        res_ready = 1'b1;
        @(negedge Clock);
        res_ready = 1'b0;
        exp_txn = (exp_txn + 1) % 65536;
        check("txn_count", txn_count, exp_txn);
        check("res_valid_done", res_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_valid_data"}, mul_valid_data, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_ack"}, mul_ack, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_product"}, res_product, 0);
        check({tag, "_txn"}, txn_count, 0);
        check({tag, "_terr"}, timeout_err, 0);
    endtask

    initial begin : stimulus
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           cyc;
        // Reset entry and release
        #3 Reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge Clock);
        #2 Reset_n = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("in_ready_after_reset", in_ready, 1);

        // Directed cases
        do_txn(32'd3, 32'd5, 34, 1, 1'b0);
        do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1'b0);
        check("max_product_const", res_product, 64'hFFFF_FFFE_0000_0001);
        do_txn(32'd0, 32'd7, 1, 1, 1'b0);
        do_txn(32'd12345, 32'd0, 1, 1, 1'b0);
        do_txn(32'hDEAD_BEEF, 32'h0000_1234, 2, 10, 1'b0);

        // Spurious done and stray res_ready while idle are ignored
        spur = 1'b1;
        res_ready = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            check("spur_in_ready", in_ready, 1);
            check("spur_valid_data", mul_valid_data, 0);
            check("spur_res_valid", res_valid, 0);
            check("spur_txn", txn_count, exp_txn);
        end
        spur = 1'b0;
        res_ready = 1'b0;

        // Randomized transactions
        for (int n = 0; n < 16; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_txn(ra, rb, $urandom_range(1, 6), $urandom_range(1, 3), 1'b0);
        end

`ifdef MULT_REQ_TIMEOUT_EN
        do_txn(32'd77, 32'd91, 1, 2, 1'b1);
        do_txn(32'd6, 32'd7, 1, 1, 1'b0);
`endif

        // Reset in the middle of a WAIT
        mdl_lat   = 40;
        mdl_never = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge Clock);
            cyc++;
        end
        in_valid = 1'b1;
        in_a = 32'd9;
        in_b = 32'd11;
        @(negedge Clock);
        in_valid = 1'b0;
        repeat (4) @(negedge Clock);
        check("pre_reset_busy", in_ready, 0);
        #2 Reset_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge Clock);
        #2 Reset_n = 1'b1;
        exp_txn = 0;
        @(negedge Clock);
        @(negedge Clock);
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_txn", txn_count, 0);
        check("post_reset_res_valid", res_valid, 0);
        do_txn(32'd21, 32'd2, 3, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
